// File: rtl/mips_register_bank_dump_if.sv
// Pipeline-side register access and debug dump stream for the MIPS register bank.
interface mips_register_bank_dump_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned NUM_READ_PORTS = 2
);
  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] ReadRegister;
  logic [NUM_READ_PORTS*DATA_WIDTH-1:0] ReadData;
  logic                                 RegWrite;
  logic [ADDR_WIDTH-1:0]                WriteRegister;
  logic [DATA_WIDTH-1:0]                WriteData;
  logic                                 DumpStart;
  logic                                 DumpBusy;
  logic                                 DumpValid;
  logic                                 DumpReady;
  logic [ADDR_WIDTH-1:0]                DumpIndex;
  logic [DATA_WIDTH-1:0]                DumpData;
  logic                                 DumpLast;
  logic                                 DumpDone;

  modport master (
    output ReadRegister, RegWrite, WriteRegister, WriteData, DumpStart, DumpReady,
    input  ReadData, DumpBusy, DumpValid, DumpIndex, DumpData, DumpLast, DumpDone
  );

  modport slave (
    input  ReadRegister, RegWrite, WriteRegister, WriteData, DumpStart, DumpReady,
    output ReadData, DumpBusy, DumpValid, DumpIndex, DumpData, DumpLast, DumpDone
  );
endinterface

// File: rtl/mips_register_bank_dump.sv
// Parametrised MIPS register bank with combinational read ports, optional bypass
// and zero register, plus a handshaked engine that streams every register in order.
module mips_register_bank_dump #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned NUM_READ_PORTS = 2,
  parameter int unsigned ZERO_REG       = 1,
  parameter int unsigned BYPASS         = 1
) (
  input logic                      ClockIn,
  input logic                      Reset,
  mips_register_bank_dump_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = '1;

  typedef enum logic {IDLE, SEND} dumpState_t;

  dumpState_t            dumpState;
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  writeEn;
  logic [ADDR_WIDTH-1:0] nextIndex;
  logic [ADDR_WIDTH-1:0] readIndex;

  assign writeEn   = bus.RegWrite && !((ZERO_REG != 0) && (bus.WriteRegister == '0));
  assign nextIndex = bus.DumpIndex + ADDR_WIDTH'(1);

  // Value register idx will hold after the current edge, so a same-edge write is captured.
  function automatic logic [DATA_WIDTH-1:0] postEdgeValue(input logic [ADDR_WIDTH-1:0] idx);
    if (writeEn && (bus.WriteRegister == idx)) begin
      return bus.WriteData;
    end
    return regs[idx];
  endfunction

  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
    end else if (writeEn) begin
      regs[bus.WriteRegister] <= bus.WriteData;
    end
  end

  // Independent read ports; register 0 is forced to zero before the bypass is considered.
  always_comb begin
    bus.ReadData = '0;
    readIndex    = '0;
    for (int p = 0; p < int'(NUM_READ_PORTS); p++) begin
      readIndex = bus.ReadRegister[p*ADDR_WIDTH +: ADDR_WIDTH];
      if ((ZERO_REG != 0) && (readIndex == '0)) begin
        bus.ReadData[p*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else if ((BYPASS != 0) && writeEn && (bus.WriteRegister == readIndex)) begin
        bus.ReadData[p*DATA_WIDTH +: DATA_WIDTH] = bus.WriteData;
      end else begin
        bus.ReadData[p*DATA_WIDTH +: DATA_WIDTH] = regs[readIndex];
      end
    end
  end

  // Dump engine: each beat is a snapshot taken on the edge that loads it and held until accepted.
  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      dumpState     <= IDLE;
      bus.DumpBusy  <= 1'b0;
      bus.DumpValid <= 1'b0;
      bus.DumpLast  <= 1'b0;
      bus.DumpDone  <= 1'b0;
      bus.DumpIndex <= '0;
      bus.DumpData  <= '0;
    end else begin
      bus.DumpDone <= 1'b0;
      case (dumpState)
        IDLE: begin
          if (bus.DumpStart) begin
            dumpState     <= SEND;
            bus.DumpBusy  <= 1'b1;
            bus.DumpValid <= 1'b1;
            bus.DumpIndex <= '0;
            bus.DumpData  <= postEdgeValue('0);
            bus.DumpLast  <= (LAST_INDEX == '0);
          end
        end
        SEND: begin
          if (bus.DumpReady) begin
            if (bus.DumpIndex == LAST_INDEX) begin
              dumpState     <= IDLE;
              bus.DumpBusy  <= 1'b0;
              bus.DumpValid <= 1'b0;
              bus.DumpLast  <= 1'b0;
              bus.DumpDone  <= 1'b1;
            end else begin
              bus.DumpIndex <= nextIndex;
              bus.DumpData  <= postEdgeValue(nextIndex);
              bus.DumpLast  <= (nextIndex == LAST_INDEX);
            end
          end
        end
        default: dumpState <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mips_register_bank_dump.md
Name: mips_register_bank_dump

Overview:
Parametrised successor to the ID-stage register bank of the MIPS pipeline.
- Generalised in data width, register count and number of read ports.
- Adds configurable write-to-read bypass and an optional hardwired-zero register.
- Adds a handshaked dump engine that streams every register, in order, to the debug unit without stalling the pipeline.

Parameters:
DATA_WIDTH, 32, register width in bits
ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH
NUM_READ_PORTS, 2, number of independent combinational read ports
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports

Ports:
ClockIn  input  1  system clock; all state updates on rising edge
Reset  input  1  asynchronous, active-low reset
ReadRegister  input  NUM_READ_PORTS*ADDR_WIDTH  packed read indices; port p uses bits [p*ADDR_WIDTH +: ADDR_WIDTH]
ReadData  output  NUM_READ_PORTS*DATA_WIDTH  packed read data, same packing
RegWrite  input  1  write enable
WriteRegister  input  ADDR_WIDTH  write index
WriteData  input  DATA_WIDTH  write data
DumpStart  input  1  request a full dump; sampled only in IDLE
DumpBusy  output  1  dump in progress
DumpValid  output  1  DumpData/DumpIndex are valid
DumpReady  input  1  consumer accepts the current beat
DumpIndex  output  ADDR_WIDTH  index of the register in DumpData
DumpData  output  DATA_WIDTH  dumped register value
DumpLast  output  1  current beat is index DEPTH-1
DumpDone  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
Reset (Reset=0, asynchronous):
- All registers are cleared to 0. FSM returns to IDLE.
- DumpBusy, DumpValid, DumpLast and DumpDone are 0. DumpIndex and DumpData are 0.
- A reset during a dump aborts it; no DumpDone is produced.

Register file:
- Write: at the rising edge with RegWrite=1, regs[WriteRegister] <= WriteData.
- If ZERO_REG=1 and WriteRegister=0, the write is dropped.
- Read: combinational, zero latency, ReadData[p] = regs[ReadRegister[p]].
- If ZERO_REG=1, index 0 always returns 0.
- If BYPASS=1, RegWrite=1 and WriteRegister == ReadRegister[p], port p returns WriteData. This does not apply to index 0 when ZERO_REG=1.
- If BYPASS=0, port p returns the old value until the next edge.
- All read ports are fully independent; any number of ports may address the same register.

Dump FSM, states IDLE and SEND:
- IDLE -> SEND when DumpStart=1.
  - On that edge: DumpIndex <= 0, DumpData <= value of register 0 (bypass rule applied), DumpValid <= 1, DumpBusy <= 1.
- In SEND, the beat transfers on an edge where DumpValid=1 and DumpReady=1.
- While DumpValid=1 and DumpReady=0, DumpIndex and DumpData are held stable. This holds even if the pipeline writes that register; the dump is a per-beat snapshot.
- On a transfer with DumpIndex < DEPTH-1:
  - DumpIndex increments.
  - DumpData loads the next register, using the value the register would have after this edge. A same-edge write to the next index is captured.
- DumpLast = DumpValid and (DumpIndex == DEPTH-1).
- On a transfer with DumpLast=1:
  - Go to IDLE; DumpValid and DumpBusy <= 0.
  - DumpDone = 1 for exactly the next cycle.
- DumpStart is ignored while DumpBusy=1.
- DumpStart asserted in the same cycle as DumpDone=1 is accepted, since the FSM is in IDLE.
- Minimum dump length is DEPTH cycles when DumpReady is held at 1.
- Register reads and writes are never blocked by the dump.

Test Plan:
- Reset then read: release Reset, read indices 0, 5 and 31 -> all ReadData = 0. Write 0xDEADBEEF to register 0 -> reads back 0 when ZERO_REG=1.
- Write/read and bypass: write 0x12345678 to register 7 while port 0 and port 1 both read 7.
  - Same cycle: both ports return 0x12345678 with BYPASS=1; old value 0 with BYPASS=0.
  - After the edge: both return 0x12345678.
- Full dump, no backpressure: preload regs[i] = i*0x11 for i = 1..31, pulse DumpStart, hold DumpReady=1.
  - 32 consecutive beats with index 0..31 and data 0, 0x11, ... 0x20F.
  - DumpLast only on index 31; DumpDone pulses once, one cycle after that beat.
- Backpressure and snapshot: during a dump, hold DumpReady=0 at index 4 for 5 cycles while writing 0xAAAA0000 to register 4.
  - DumpData stays at the old regs[4] throughout the stall.
  - The next beat is index 5; a later read of register 4 returns 0xAAAA0000.
- Capture of a same-edge write: during the transfer edge of index 9, write 0x0BADF00D to register 10 -> the beat for index 10 carries 0x0BADF00D.
- Restart and reset: pulse DumpStart at index 12 -> ignored, dump continues. Assert Reset at index 20 -> outputs go to 0 immediately, no DumpDone, and a new DumpStart begins again at index 0.
